// File: rtl/alu_ctrl.sv
// ALU controller for a small RV32I subset. An instruction is taken in IDLE,
// decoded against the register file in DECODE, executed on an external
// combinational ALU in EXEC, and written back in WB.

package cpu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_XOR = 3'd2,
    ALU_OR  = 3'd3,
    ALU_AND = 3'd4
  } alu_op_t;
endpackage

module alu_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output alu_op_t     alu_op,
  output logic [31:0] src_a,
  output logic [31:0] src_b,
  input  logic [31:0] alu_result,
  output logic        rd_we,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_wdata,
  output logic        illegal,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_instr;
  logic [31:0] r_srcA;
  logic [31:0] r_srcB;
  alu_op_t     r_aluOp;
  logic [4:0]  r_rdAddr;
  logic [31:0] r_rdWdata;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic        w_legal;
  alu_op_t     w_decOp;
  logic [31:0] w_srcB;
  logic        w_accept;
  logic        w_loadOps;
  logic        w_capture;

  assign w_opcode = r_instr[6:0];
  assign w_funct3 = r_instr[14:12];
  assign w_funct7 = r_instr[31:25];

  // Register addresses always follow the latched word; the register file answers combinationally.
  assign rs1_addr = r_instr[19:15];
  assign rs2_addr = r_instr[24:20];

  assign alu_op   = r_aluOp;
  assign src_a    = r_srcA;
  assign src_b    = r_srcB;
  assign rd_addr  = r_rdAddr;
  assign rd_wdata = r_rdWdata;

  // Writes to x0 are suppressed so the register file never sees a pulse for them.
  assign rd_we = (r_state == WB) && (r_rdAddr != 5'd0);

  // Decode the latched word into legality, ALU operation and second operand.
  always_comb begin
    w_legal = 1'b0;
    w_decOp = ALU_ADD;
    w_srcB  = rs2_data;
    if (w_opcode == 7'b0110011) begin
      if (w_funct7 == 7'b0000000) begin
        case (w_funct3)
          3'b000:  begin w_legal = 1'b1; w_decOp = ALU_ADD; end
          3'b100:  begin w_legal = 1'b1; w_decOp = ALU_XOR; end
          3'b110:  begin w_legal = 1'b1; w_decOp = ALU_OR;  end
          3'b111:  begin w_legal = 1'b1; w_decOp = ALU_AND; end
          default: w_legal = 1'b0;
        endcase
      end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
        w_legal = 1'b1;
        w_decOp = ALU_SUB;
      end
    end else if (w_opcode == 7'b0010011) begin
      w_srcB = {{20{r_instr[31]}}, r_instr[31:20]};
      case (w_funct3)
        3'b000:  begin w_legal = 1'b1; w_decOp = ALU_ADD; end
        3'b100:  begin w_legal = 1'b1; w_decOp = ALU_XOR; end
        3'b110:  begin w_legal = 1'b1; w_decOp = ALU_OR;  end
        3'b111:  begin w_legal = 1'b1; w_decOp = ALU_AND; end
        default: w_legal = 1'b0;
      endcase
    end
  end

  // State register; reset always lands in IDLE, aborting any instruction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state logic plus the handshake, status and datapath load strobes.
  always_comb begin
    w_nextState = r_state;
    instr_ready = 1'b0;
    busy        = 1'b1;
    illegal     = 1'b0;
    w_accept    = 1'b0;
    w_loadOps   = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (instr_valid) begin
          w_accept    = 1'b1;
          w_nextState = DECODE;
        end
      end
      DECODE: begin
        if (w_legal) begin
          w_loadOps   = 1'b1;
          w_nextState = EXEC;
        end else begin
          illegal     = 1'b1;
          w_nextState = IDLE;
        end
      end
      EXEC: begin
        w_capture   = 1'b1;
        w_nextState = WB;
      end
      WB: begin
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath registers only move on their strobes, so they hold through IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instr   <= 32'h0;
      r_srcA    <= 32'h0;
      r_srcB    <= 32'h0;
      r_aluOp   <= ALU_ADD;
      r_rdAddr  <= 5'd0;
      r_rdWdata <= 32'h0;
    end else begin
      if (w_accept) r_instr <= instr;
      if (w_loadOps) begin
        r_srcA  <= rs1_data;
        r_srcB  <= w_srcB;
        r_aluOp <= w_decOp;
      end
      if (w_capture) begin
        r_rdWdata <= alu_result;
        r_rdAddr  <= r_instr[11:7];
      end
    end
  end

endmodule
